// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to a single-ported data memory, waits for ack,
// and aligns/extends load data into the MEM/WB register. Optional macro: MEM_MISALIGN_CHECK_EN.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        w_enable_i,
    input  logic [4:0]  w_addr_i,
    input  logic [31:0] w_data_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_req_o,
    output logic        w_enable_o,
    output logic [4:0]  w_addr_o,
    output logic [31:0] w_data_o,
    output logic        misalign_o
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE = 4'b0000,
        OP_LB   = 4'b0001,
        OP_LH   = 4'b0010,
        OP_LW   = 4'b0011,
        OP_LBU  = 4'b0100,
        OP_LHU  = 4'b0101,
        OP_SB   = 4'b1001,
        OP_SH   = 4'b1010,
        OP_SW   = 4'b1011
    } mem_op_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_e      r_state, w_state_next;

    logic        r_mem_req, w_mem_req_next;
    logic        r_mem_we, w_mem_we_next;
    logic [31:0] r_mem_addr, w_mem_addr_next;
    logic [31:0] r_mem_wdata, w_mem_wdata_next;
    logic [3:0]  r_mem_be, w_mem_be_next;

    logic        r_w_enable, w_w_enable_next;
    logic [4:0]  r_w_addr, w_w_addr_next;
    logic [31:0] r_w_data, w_w_data_next;
    logic        r_misalign, w_misalign_next;

    // Load context captured at issue, consumed when the ack arrives.
    logic        r_ld_is_load, w_ld_is_load_next;
    logic [1:0]  r_ld_size, w_ld_size_next;
    logic        r_ld_signed, w_ld_signed_next;
    logic [1:0]  r_ld_off, w_ld_off_next;
    logic        r_ld_wen, w_ld_wen_next;
    logic [4:0]  r_ld_waddr, w_ld_waddr_next;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic [1:0]  w_size;
    logic        w_signed;
    logic [1:0]  w_off;
    logic        w_misaligned;
    logic [31:0] w_load_data;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = SZ_WORD;
        w_signed   = 1'b0;
        case (mem_op_i)
            OP_LB:  begin w_is_load  = 1'b1; w_size = SZ_BYTE; w_signed = 1'b1; end
            OP_LH:  begin w_is_load  = 1'b1; w_size = SZ_HALF; w_signed = 1'b1; end
            OP_LW:  begin w_is_load  = 1'b1; w_size = SZ_WORD; end
            OP_LBU: begin w_is_load  = 1'b1; w_size = SZ_BYTE; end
            OP_LHU: begin w_is_load  = 1'b1; w_size = SZ_HALF; end
            OP_SB:  begin w_is_store = 1'b1; w_size = SZ_BYTE; end
            OP_SH:  begin w_is_store = 1'b1; w_size = SZ_HALF; end
            OP_SW:  begin w_is_store = 1'b1; w_size = SZ_WORD; end
            default: ;
        endcase
    end

    assign w_is_mem = w_is_load | w_is_store;
    assign w_off    = mem_addr_i[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misaligned = w_is_mem &&
                          (((w_size == SZ_HALF) && w_off[0]) ||
                           ((w_size == SZ_WORD) && (w_off != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{data[7:0]}};
            SZ_HALF: d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(
        input logic [31:0] rdata,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        sgn
    );
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        logic [31:0] res;
        sh_b = rdata >> {off, 3'b000};
        sh_h = rdata >> {off[1], 4'b0000};
        case (size)
            SZ_BYTE: res = {{24{sgn & sh_b[7]}}, sh_b[7:0]};
            SZ_HALF: res = {{16{sgn & sh_h[15]}}, sh_h[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    assign w_load_data = load_extract(mem_rdata_i, r_ld_size, r_ld_off, r_ld_signed);

    // Misaligned accesses are rejected in the issue cycle, so they never stall.
    assign stall_req_o = ((r_state == S_IDLE) && valid_i && w_is_mem && !w_misaligned) ||
                         ((r_state == S_WAIT) && !mem_ack_i);

    always_comb begin
        w_state_next      = r_state;
        w_mem_req_next    = r_mem_req;
        w_mem_we_next     = r_mem_we;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_mem_be_next     = r_mem_be;
        w_w_enable_next   = 1'b0;
        w_w_addr_next     = r_w_addr;
        w_w_data_next     = r_w_data;
        w_misalign_next   = 1'b0;
        w_ld_is_load_next = r_ld_is_load;
        w_ld_size_next    = r_ld_size;
        w_ld_signed_next  = r_ld_signed;
        w_ld_off_next     = r_ld_off;
        w_ld_wen_next     = r_ld_wen;
        w_ld_waddr_next   = r_ld_waddr;

        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    if (!w_is_mem) begin
                        w_w_enable_next = w_enable_i;
                        w_w_addr_next   = w_addr_i;
                        w_w_data_next   = w_data_i;
                    end else if (w_misaligned) begin
                        w_misalign_next = 1'b1;
                    end else begin
                        w_state_next      = S_WAIT;
                        w_mem_req_next    = 1'b1;
                        w_mem_we_next     = w_is_store;
                        w_mem_addr_next   = {mem_addr_i[31:2], 2'b00};
                        w_mem_be_next     = w_is_store ? store_be(w_size, w_off) : 4'b1111;
                        w_mem_wdata_next  = w_is_store ? store_data(w_size, mem_wdata_i) : '0;
                        w_ld_is_load_next = w_is_load;
                        w_ld_size_next    = w_size;
                        w_ld_signed_next  = w_signed;
                        w_ld_off_next     = w_off;
                        w_ld_wen_next     = w_enable_i;
                        w_ld_waddr_next   = w_addr_i;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack_i) begin
                    w_state_next   = S_IDLE;
                    w_mem_req_next = 1'b0;
                    w_mem_we_next  = 1'b0;
                    if (r_ld_is_load) begin
                        w_w_enable_next = r_ld_wen;
                        w_w_addr_next   = r_ld_waddr;
                        w_w_data_next   = w_load_data;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_w_enable   <= 1'b0;
            r_w_addr     <= '0;
            r_w_data     <= '0;
            r_misalign   <= 1'b0;
            r_ld_is_load <= 1'b0;
            r_ld_size    <= SZ_WORD;
            r_ld_signed  <= 1'b0;
            r_ld_off     <= '0;
            r_ld_wen     <= 1'b0;
            r_ld_waddr   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_mem_be     <= w_mem_be_next;
            r_w_enable   <= w_w_enable_next;
            r_w_addr     <= w_w_addr_next;
            r_w_data     <= w_w_data_next;
            r_misalign   <= w_misalign_next;
            r_ld_is_load <= w_ld_is_load_next;
            r_ld_size    <= w_ld_size_next;
            r_ld_signed  <= w_ld_signed_next;
            r_ld_off     <= w_ld_off_next;
            r_ld_wen     <= w_ld_wen_next;
            r_ld_waddr   <= w_ld_waddr_next;
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_be_o    = r_mem_be;
    assign w_enable_o  = r_w_enable;
    assign w_addr_o    = r_w_addr;
    assign w_data_o    = r_w_data;
    assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; honours MEM_MISALIGN_CHECK_EN for the LW 0x301 case.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        w_enable_i;
    logic [4:0]  w_addr_i;
    logic [31:0] w_data_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_req_o;
    logic        w_enable_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;
    logic        misalign_o;

    int unsigned n_pass;
    int unsigned n_total;
    int unsigned stall_cnt;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .w_enable_i  (w_enable_i),
        .w_addr_i    (w_addr_i),
        .w_data_i    (w_data_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_req_o (stall_req_o),
        .w_enable_o  (w_enable_o),
        .w_addr_o    (w_addr_o),
        .w_data_o    (w_data_o),
        .misalign_o  (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        valid_i     = 1'b0;
        w_enable_i  = 1'b0;
        w_addr_i    = '0;
        w_data_i    = '0;
        mem_op_i    = 4'b0000;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req",   {31'b0, mem_req_o},  32'd0);
        chk("rst_we",    {31'b0, mem_we_o},   32'd0);
        chk("rst_be",    {28'b0, mem_be_o},   32'd0);
        chk("rst_addr",  mem_addr_o,          32'd0);
        chk("rst_wdata", mem_wdata_o,         32'd0);
        chk("rst_wen",   {31'b0, w_enable_o}, 32'd0);
        chk("rst_waddr", {27'b0, w_addr_o},   32'd0);
        chk("rst_wdat",  w_data_o,            32'd0);
        chk("rst_mis",   {31'b0, misalign_o}, 32'd0);
        rst = 1'b0;
        tick();

        // ADD result passes through with latency 1
        valid_i = 1'b1; w_enable_i = 1'b1; w_addr_i = 5'd5; w_data_i = 32'h1234; mem_op_i = 4'b0000;
        #1;
        chk("add_stall", {31'b0, stall_req_o}, 32'd0);
        tick();
        chk("add_wen",   {31'b0, w_enable_o}, 32'd1);
        chk("add_waddr", {27'b0, w_addr_o},   32'd5);
        chk("add_wdata", w_data_o,            32'h1234);
        idle_inputs();
        #1;
        chk("add_stall2", {31'b0, stall_req_o}, 32'd0);
        tick();
        chk("bubble_wen", {31'b0, w_enable_o}, 32'd0);

        // LB at 0x103, ack on the fourth WAIT cycle
        valid_i = 1'b1; w_enable_i = 1'b1; w_addr_i = 5'd7; mem_op_i = 4'b0001; mem_addr_i = 32'h103;
        #1;
        stall_cnt = {31'b0, stall_req_o};
        tick();
        chk("lb_req",  {31'b0, mem_req_o}, 32'd1);
        chk("lb_we",   {31'b0, mem_we_o},  32'd0);
        chk("lb_be",   {28'b0, mem_be_o},  32'hF);
        chk("lb_addr", mem_addr_o,         32'h100);
        idle_inputs();
        mem_addr_i = 32'hFFFF_FFFF; mem_op_i = 4'b1011; w_addr_i = 5'd31;
        for (int i = 0; i < 3; i++) begin
            #1;
            stall_cnt += {31'b0, stall_req_o};
            chk("lb_wait_wen", {31'b0, w_enable_o}, 32'd0);
            tick();
            chk("lb_hold_addr", mem_addr_o,         32'h100);
            chk("lb_hold_req",  {31'b0, mem_req_o}, 32'd1);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h80FF_0000;
        #1;
        stall_cnt += {31'b0, stall_req_o};
        chk("lb_stall_cycles", stall_cnt, 32'd4);
        tick();
        idle_inputs();
        chk("lb_wen",   {31'b0, w_enable_o}, 32'd1);
        chk("lb_waddr", {27'b0, w_addr_o},   32'd7);
        chk("lb_data",  w_data_o,            32'hFFFF_FF80);
        chk("lb_drop",  {31'b0, mem_req_o},  32'd0);

        // LBU at 0x103, immediate ack
        valid_i = 1'b1; w_enable_i = 1'b1; w_addr_i = 5'd8; mem_op_i = 4'b0100; mem_addr_i = 32'h103;
        tick();
        idle_inputs();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h80FF_0000;
        tick();
        idle_inputs();
        chk("lbu_data", w_data_o, 32'h0000_0080);
        chk("lbu_wen",  {31'b0, w_enable_o}, 32'd1);

        // LH at 0x102 (sign) then LHU at 0x100 (zero)
        valid_i = 1'b1; w_enable_i = 1'b1; w_addr_i = 5'd9; mem_op_i = 4'b0010; mem_addr_i = 32'h102;
        tick();
        idle_inputs();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8001_1234;
        tick();
        idle_inputs();
        chk("lh_data", w_data_o, 32'hFFFF_8001);
        valid_i = 1'b1; w_enable_i = 1'b1; w_addr_i = 5'd9; mem_op_i = 4'b0101; mem_addr_i = 32'h100;
        tick();
        idle_inputs();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8001_F234;
        tick();
        idle_inputs();
        chk("lhu_data", w_data_o, 32'h0000_F234);

        // SH at 0x202
        valid_i = 1'b1; w_enable_i = 1'b1; w_addr_i = 5'd3; mem_op_i = 4'b1010;
        mem_addr_i = 32'h202; mem_wdata_i = 32'hAAAA_BEEF;
        #1;
        chk("sh_stall", {31'b0, stall_req_o}, 32'd1);
        tick();
        idle_inputs();
        chk("sh_we",    {31'b0, mem_we_o}, 32'd1);
        chk("sh_be",    {28'b0, mem_be_o}, 32'hC);
        chk("sh_wdata", mem_wdata_o,       32'hBEEF_BEEF);
        chk("sh_addr",  mem_addr_o,        32'h200);
        mem_ack_i = 1'b1;
        tick();
        idle_inputs();
        chk("sh_wen", {31'b0, w_enable_o}, 32'd0);
        chk("sh_req", {31'b0, mem_req_o},  32'd0);

        // SB at 0x101
        valid_i = 1'b1; mem_op_i = 4'b1001; mem_addr_i = 32'h101; mem_wdata_i = 32'h1234_565A;
        tick();
        idle_inputs();
        chk("sb_be",    {28'b0, mem_be_o}, 32'h2);
        chk("sb_wdata", mem_wdata_o,       32'h5A5A_5A5A);
        mem_ack_i = 1'b1;
        tick();
        idle_inputs();

        // Reset during WAIT, late ack ignored
        valid_i = 1'b1; w_enable_i = 1'b1; w_addr_i = 5'd4; mem_op_i = 4'b0011; mem_addr_i = 32'h400;
        tick();
        idle_inputs();
        chk("rw_req", {31'b0, mem_req_o}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_req_after", {31'b0, mem_req_o},  32'd0);
        chk("rw_wen_after", {31'b0, w_enable_o}, 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        #1;
        chk("rw_stall", {31'b0, stall_req_o}, 32'd0);
        tick();
        idle_inputs();
        chk("rw_late_req", {31'b0, mem_req_o},  32'd0);
        chk("rw_late_wen", {31'b0, w_enable_o}, 32'd0);
        valid_i = 1'b1; mem_op_i = 4'b0011; mem_addr_i = 32'h500;
        #1;
        chk("rw_idle_stall", {31'b0, stall_req_o}, 32'd1);
        tick();
        idle_inputs();
        mem_ack_i = 1'b1;
        tick();
        idle_inputs();

        // LW at 0x301
        valid_i = 1'b1; w_enable_i = 1'b1; w_addr_i = 5'd6; mem_op_i = 4'b0011; mem_addr_i = 32'h301;
`ifdef MEM_MISALIGN_CHECK_EN
        #1;
        chk("mis_stall", {31'b0, stall_req_o}, 32'd0);
        tick();
        idle_inputs();
        chk("mis_pulse", {31'b0, misalign_o}, 32'd1);
        chk("mis_req",   {31'b0, mem_req_o},  32'd0);
        chk("mis_wen",   {31'b0, w_enable_o}, 32'd0);
        tick();
        chk("mis_pulse_end", {31'b0, misalign_o}, 32'd0);
        chk("mis_wen2",      {31'b0, w_enable_o}, 32'd0);
`else
        #1;
        chk("lw_stall", {31'b0, stall_req_o}, 32'd1);
        tick();
        idle_inputs();
        chk("lw_addr", mem_addr_o,          32'h300);
        chk("lw_req",  {31'b0, mem_req_o},  32'd1);
        chk("lw_mis",  {31'b0, misalign_o}, 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        chk("lw_data",  w_data_o,            32'hDEAD_BEEF);
        chk("lw_wen",   {31'b0, w_enable_o}, 32'd1);
        chk("lw_waddr", {27'b0, w_addr_o},   32'd6);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 valid_i  in  1  EX/MEM slot holds a live instruction.
REQ-004 w_enable_i / w_addr_i / w_data_i  in  1/5/32  writeback request, destination register, ALU result.
REQ-005 mem_op_i  in  4  0000 NONE, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; any other code is NONE.
REQ-006 mem_addr_i / mem_wdata_i  in  32/32  effective address, store data.
REQ-007 mem_req_o / mem_we_o  out  1/1  memory request, write strobe.
REQ-008 mem_addr_o / mem_wdata_o / mem_be_o  out  32/32/4  word-aligned address, lane-placed data, byte enables.
REQ-009 mem_ack_i / mem_rdata_i  in  1/32  request complete, read word.
REQ-010 stall_req_o  out  1  freeze IF..EX, combinational.
REQ-011 w_enable_o / w_addr_o / w_data_o  out  1/5/32  registered MEM/WB outputs to writeback.
REQ-012 misalign_o  out  1  one-cycle misaligned-access pulse.

Function
REQ-013 FSM states: IDLE and WAIT.
REQ-014 IDLE, valid_i=1, op NONE: next cycle w_*_o = w_*_i (latency 1); w_enable_o=0 when valid_i=0.
REQ-015 IDLE, valid_i=1, memory op: register request and enter WAIT; mem_req_o=1 from the next cycle.
REQ-016 WAIT: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o are held stable until mem_ack_i=1 is sampled.
REQ-017 mem_ack_i is ignored while mem_req_o=0.
REQ-018 stall_req_o = (IDLE & valid_i & memory op) | (WAIT & ~mem_ack_i).
REQ-019 While stalled, w_enable_o=0, so writeback receives a bubble.
REQ-020 Ack in WAIT: drop mem_req_o next cycle, return to IDLE and register the result; a load reaches w_*_o one cycle after ack.
REQ-021 mem_addr_o = {mem_addr_i[31:2],2'b00}; off = mem_addr_i[1:0].
REQ-022 SB: be = 4'b0001<<off, byte replicated x4.
REQ-022a SH: be = off[1] ? 1100 : 0011, half replicated x2.
REQ-022b SW: be = 1111.
REQ-023 Loads: be = 1111, we = 0.
REQ-023a LB/LBU: extract mem_rdata_i[8*off+:8].
REQ-023b LH/LHU: extract mem_rdata_i[16*off[1]+:16].
REQ-023c Sign-extend LB/LH, zero-extend LBU/LHU; LW is passed unchanged.
REQ-024 Stores complete with w_enable_o=0; loads complete with w_enable_o = w_enable_i latched at issue.
REQ-025 w_addr_o=0 is passed through unchanged; the register file discards it.
REQ-026 Operands are latched at issue; input changes during WAIT have no effect.

Reset
REQ-027 Reset drives state=IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, w_enable_o=0, w_addr_o=5'b0, w_data_o=32'h0, misalign_o=0.
REQ-028 Reset during WAIT abandons the access: mem_req_o=0 the next cycle, no writeback, and any late ack is ignored.

Configuration
REQ-029 Macro MEM_MISALIGN_CHECK_EN.
REQ-030 Defined: LH/LHU/SH with off[0]=1, or LW/SW with off!=0, issue no request, pulse misalign_o one cycle, write nothing back, and never assert stall_req_o.
REQ-031 Undefined: misalign_o is tied to 0, the address is aligned down per REQ-021, and offset low bits beyond the access size are ignored.

Verification
REQ-032 ADD result: w_addr_i=5, w_data_i=32'h1234, op NONE -> next cycle w_enable_o=1, w_addr_o=5, w_data_o=32'h1234; stall_req_o never asserted.
REQ-033 LB at addr 32'h103 with rdata 32'h80FF_0000 and ack after 3 WAIT cycles -> mem_addr_o=32'h100, be=1111, stall for 4 cycles, w_data_o=32'hFFFF_FF80; the same access as LBU gives 32'h0000_0080.
REQ-034 SH at addr 32'h202 with wdata 32'hAAAA_BEEF -> mem_we_o=1, be=1100, mem_wdata_o=32'hBEEF_BEEF, w_enable_o=0 after ack.
REQ-035 rst=1 asserted in WAIT, then ack asserted next cycle -> mem_req_o=0, w_enable_o=0, state=IDLE, no writeback.
REQ-036 LW at addr 32'h301: with MEM_MISALIGN_CHECK_EN -> misalign_o=1 for one cycle, mem_req_o=0, w_enable_o=0; without it -> mem_addr_o=32'h300 and the normal load completes.
